// File: rtl/sensor_threshold_conditioner_pkg.sv
// Shared constants and types for the sensor threshold conditioner.
package sensor_threshold_conditioner_pkg;
    `include "irr_defs.vh"

    typedef logic [NUM_CH-1:0] ch_vec_t;
endpackage

// File: rtl/irr_defs.vh
// Channel indices shared by the threshold conditioner and the irrigation comparator wrapper.
`ifndef IRR_DEFS_VH
`define IRR_DEFS_VH
localparam int CH_AIR_T  = 0;
localparam int CH_SOIL_T = 1;
localparam int CH_AIR_H  = 2;
localparam int CH_SOIL_M = 3;
localparam int NUM_CH    = 4;
`endif

// File: rtl/sensor_threshold_conditioner_channel.sv
// One channel: hysteresis compare against set/clear thresholds plus N-sample persistence.
module sensor_channel_cond #(
    parameter int DATA_W     = 8,
    parameter int DEBOUNCE_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic              clear,
    input  logic [DATA_W-1:0] raw,
    input  logic [DATA_W-1:0] thr_hi,
    input  logic [DATA_W-1:0] thr_lo,
    output logic              active,
    output logic              cfg_err
);
    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_N - 1);

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] lo_eff;
    logic              cand;

    // An inverted threshold pair collapses to a single level rather than a dead band.
    always_comb begin
        lo_eff = (thr_lo > thr_hi) ? thr_hi : thr_lo;
        cand   = active ? (raw >= lo_eff) : (raw >= thr_hi);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else if (sample_valid) begin
            cfg_err <= (thr_lo > thr_hi);
            if (cand == active) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                active <= ~active;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (clear) begin
            active <= 1'b0;
            cnt    <= '0;
        end
    end
endmodule

// File: rtl/sensor_threshold_conditioner.sv
// Four-channel sensor conditioner with a staleness watchdog feeding the irrigation comparator.
module sensor_threshold_conditioner
    import sensor_threshold_conditioner_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEBOUNCE_N = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [DATA_W-1:0]        raw_air_temp,
    input  logic [DATA_W-1:0]        raw_soil_temp,
    input  logic [DATA_W-1:0]        raw_air_hum,
    input  logic [DATA_W-1:0]        raw_soil_moist,
    input  logic [NUM_CH*DATA_W-1:0] thr_hi,
    input  logic [NUM_CH*DATA_W-1:0] thr_lo,
    output logic                     AirTemperature,
    output logic                     SoilTemprature,
    output logic                     AirHumidity,
    output logic                     SoilMoisture,
    output logic                     out_valid,
    output logic                     stale,
    output logic [NUM_CH-1:0]        cfg_err
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0]         wd;
    logic                    timeout_hit;
    ch_vec_t                 active;
    logic [NUM_CH-1:0][DATA_W-1:0] raw;

    always_comb begin
        raw            = '0;
        raw[CH_AIR_T]  = raw_air_temp;
        raw[CH_SOIL_T] = raw_soil_temp;
        raw[CH_AIR_H]  = raw_air_hum;
        raw[CH_SOIL_M] = raw_soil_moist;
    end

    // A sample arriving on the expiry cycle takes priority over the timeout.
    assign timeout_hit = !sample_valid && (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd        <= '0;
            stale     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= sample_valid;
            if (sample_valid) begin
                wd    <= '0;
                stale <= 1'b0;
            end else if (wd != WD_MAX) begin
                wd <= wd + WD_W'(1);
                if (timeout_hit) stale <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sensor_channel_cond #(
            .DATA_W    (DATA_W),
            .DEBOUNCE_N(DEBOUNCE_N)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .sample_valid(sample_valid),
            .clear       (timeout_hit),
            .raw         (raw[c]),
            .thr_hi      (thr_hi[c*DATA_W +: DATA_W]),
            .thr_lo      (thr_lo[c*DATA_W +: DATA_W]),
            .active      (active[c]),
            .cfg_err     (cfg_err[c])
        );
    end

    assign AirTemperature = active[CH_AIR_T];
    assign SoilTemprature = active[CH_SOIL_T];
    assign AirHumidity    = active[CH_AIR_H];
    assign SoilMoisture   = active[CH_SOIL_M];
endmodule

// File: tb/tb_sensor_threshold_conditioner.sv
// Scoreboard bench: stimulus queues expected indications, a negedge monitor checks each out_valid.
module tb_sensor_threshold_conditioner;
    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [7:0]  raw0, raw1, raw2, raw3;
    logic [31:0] thr_hi, thr_lo;
    logic        o_at, o_st, o_ah, o_sm, out_valid, stale;
    logic [3:0]  cfg_err;

    logic        sv1;
    logic [7:0]  raw1_0;
    logic        d1_at, d1_st, d1_ah, d1_sm, d1_ov, d1_stale;
    logic [3:0]  d1_cfg;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] ind;
        logic [3:0] cfg;
        logic       stale;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    sensor_threshold_conditioner #(.DATA_W(8), .DEBOUNCE_N(3), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .raw_air_temp(raw0), .raw_soil_temp(raw1), .raw_air_hum(raw2), .raw_soil_moist(raw3),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .AirTemperature(o_at), .SoilTemprature(o_st), .AirHumidity(o_ah), .SoilMoisture(o_sm),
        .out_valid(out_valid), .stale(stale), .cfg_err(cfg_err)
    );

    sensor_threshold_conditioner #(.DATA_W(8), .DEBOUNCE_N(1), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst), .sample_valid(sv1),
        .raw_air_temp(raw1_0), .raw_soil_temp(8'd0), .raw_air_hum(8'd0), .raw_soil_moist(8'd0),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .AirTemperature(d1_at), .SoilTemprature(d1_st), .AirHumidity(d1_ah), .SoilMoisture(d1_sm),
        .out_valid(d1_ov), .stale(d1_stale), .cfg_err(d1_cfg)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 16'd1, 16'd0);
            end else begin
                e = q.pop_front();
                chk("ind", {12'd0, o_sm, o_ah, o_st, o_at}, {12'd0, e.ind});
                chk("cfg_err", {12'd0, cfg_err}, {12'd0, e.cfg});
                chk("stale_on_sample", {15'd0, stale}, {15'd0, e.stale});
            end
        end
    end

    task automatic sample(input logic [7:0] a, b, c, d, input logic [3:0] ind, input logic [3:0] cfg);
        raw0 = a; raw1 = b; raw2 = c; raw3 = d;
        sample_valid = 1'b1;
        q.push_back('{ind: ind, cfg: cfg, stale: 1'b0});
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    initial begin
        logic stale_seen;
        int   guard;
        rst = 1'b1; sample_valid = 1'b1; sv1 = 1'b1;
        raw0 = 8'd255; raw1 = 8'd255; raw2 = 8'd255; raw3 = 8'd255; raw1_0 = 8'd255;
        thr_hi = {4{8'd100}};
        thr_lo = {4{8'd80}};

        // reset with strobes and saturated samples held active
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ind", {12'd0, o_sm, o_ah, o_st, o_at}, 16'd0);
        chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
        chk("reset_stale", {15'd0, stale}, 16'd0);
        chk("reset_cfg", {12'd0, cfg_err}, 16'd0);
        rst = 1'b0; sample_valid = 1'b0; sv1 = 1'b0; raw1_0 = 8'd0;

        // hysteresis on air temp
        repeat (2) sample(100, 0, 0, 0, 4'b0000, 4'b0000);
        sample(100, 0, 0, 0, 4'b0001, 4'b0000);
        repeat (5) sample(90, 0, 0, 0, 4'b0001, 4'b0000);
        repeat (3) sample(80, 0, 0, 0, 4'b0001, 4'b0000);
        repeat (2) sample(79, 0, 0, 0, 4'b0001, 4'b0000);
        sample(79, 0, 0, 0, 4'b0000, 4'b0000);

        // single-sample glitch on soil moisture restarts the persistence count
        sample(0, 0, 0, 101, 4'b0000, 4'b0000);
        sample(0, 0, 0, 101, 4'b0000, 4'b0000);
        sample(0, 0, 0, 50,  4'b0000, 4'b0000);
        sample(0, 0, 0, 101, 4'b0000, 4'b0000);
        sample(0, 0, 0, 101, 4'b0000, 4'b0000);
        sample(0, 0, 0, 101, 4'b1000, 4'b0000);

        // staleness: soil temp active, then feed stops
        sample(0, 200, 0, 101, 4'b1000, 4'b0000);
        sample(0, 200, 0, 101, 4'b1000, 4'b0000);
        sample(0, 200, 0, 101, 4'b1010, 4'b0000);
        repeat (15) @(posedge clk);
        #1;
        chk("pre_timeout_stale", {15'd0, stale}, 16'd0);
        chk("pre_timeout_ind", {12'd0, o_sm, o_ah, o_st, o_at}, 16'h000a);
        @(posedge clk);
        #1;
        chk("timeout_stale", {15'd0, stale}, 16'd1);
        chk("timeout_ind", {12'd0, o_sm, o_ah, o_st, o_at}, 16'd0);
        chk("timeout_no_out_valid", {15'd0, out_valid}, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("stale_held", {15'd0, stale}, 16'd1);
        sample(0, 200, 0, 0, 4'b0000, 4'b0000);
        chk("stale_cleared", {15'd0, stale}, 16'd0);
        sample(0, 200, 0, 0, 4'b0000, 4'b0000);
        sample(0, 200, 0, 0, 4'b0010, 4'b0000);

        // inverted thresholds on air humidity: lo_eff collapses to thr_hi
        thr_lo[23:16] = 8'd120;
        sample(0, 200, 100, 0, 4'b0010, 4'b0100);
        sample(0, 200, 100, 0, 4'b0010, 4'b0100);
        sample(0, 200, 100, 0, 4'b0110, 4'b0100);
        sample(0, 200, 100, 0, 4'b0110, 4'b0100);
        sample(0, 200, 99,  0, 4'b0110, 4'b0100);
        sample(0, 200, 99,  0, 4'b0110, 4'b0100);
        sample(0, 200, 99,  0, 4'b0010, 4'b0100);
        thr_lo[23:16] = 8'd80;
        sample(0, 200, 0, 0, 4'b0010, 4'b0000);

        // sample lands on the expiry cycle: stale must never rise
        stale_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1 stale_seen = stale_seen | stale;
        end
        sample(0, 200, 0, 0, 4'b0010, 4'b0000);
        #0 stale_seen = stale_seen | stale;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 stale_seen = stale_seen | stale;
        end
        chk("boundary_no_stale", {15'd0, stale_seen}, 16'd0);

        // DEBOUNCE_N=1 build flips on the first qualifying sample
        chk("n1_before", {15'd0, d1_at}, 16'd0);
        raw1_0 = 8'd100; sv1 = 1'b1;
        @(posedge clk);
        #1 sv1 = 1'b0;
        chk("n1_flip", {15'd0, d1_at}, 16'd1);
        chk("n1_out_valid", {15'd0, d1_ov}, 16'd1);

        // drain scoreboard
        guard = 0;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        chk("scoreboard_drained", 16'(q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
